// File: rtl/systolic_row_feeder_pkg.sv
// Shared definitions for the systolic array edge feeders (west rows and
// north columns).
//   feeder_state_t : feeder control states
//   lane_w()       : width of one skew-pipeline lane word (operand plus valid tag)
package systolic_row_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  // Lane word layout is {valid, data}; LANE_W = DATA_W + 1.
  function automatic int unsigned lane_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/systolic_row_feeder_skew_delay_line.sv
// Per-lane skew delay: DEPTH delay registers followed by the lane output
// register, so the total latency is DEPTH+1 cycles. DEPTH=0 degenerates to
// just the output register.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset, clears every stage
//   d_i    lane word entering the pipeline
//   q_o    lane word leaving the output register
module skew_delay_line #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH+1];
  logic [WIDTH-1:0] sr_d [DEPTH+1];

  always_comb begin
    sr_d[0] = d_i;
    for (int unsigned k = 1; k < DEPTH + 1; k++) begin
      sr_d[k] = sr_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < DEPTH + 1; k++) begin
      if (rst_i) sr_q[k] <= '0;
      else       sr_q[k] <= sr_d[k];
    end
  end

  assign q_o = sr_q[DEPTH];

endmodule

// File: rtl/systolic_row_feeder.sv
// West-edge feeder for the systolic PE array. Accepts one N-lane operand
// vector per beat (valid/ready) and skews it so lane i reaches its row i
// cycles after lane 0. Free-running: missing beats become zero bubbles.
// After the last beat, N-1 zero cycles flush the final wavefront, then done
// pulses for one cycle.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake (in_ready depends on state only)
//   in_data              N lanes, lane i = bits [i*DATA_W +: DATA_W]
//   in_last              marks the final vector of the operand block
//   row_out              skewed lane data to the array rows
//   row_vld              per-lane tag, 1 = real operand, 0 = bubble/flush
//   busy                 feeder not idle
//   done                 one-cycle pulse when the flush completes
module systolic_row_feeder
  import systolic_row_feeder_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [N*DATA_W-1:0] row_out,
  output logic [N-1:0]      row_vld,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LANE_W = lane_w(DATA_W);
  localparam int unsigned CNT_W  = $clog2(N);

  feeder_state_t    state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             accept;

  assign in_ready = (state_q == IDLE) || (state_q == FEED);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      IDLE, FEED: begin
        if (accept) begin
          if (in_last) begin
            state_d     = DRAIN;
            drain_cnt_d = CNT_W'(N - 1);
          end else begin
            state_d = FEED;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q - CNT_W'(1);
        // Count 1 is the final flush cycle; DONE then coincides with the
        // last operand sitting on lane N-1.
        if (drain_cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [LANE_W-1:0] lane_in;
    logic [LANE_W-1:0] lane_out;

    assign lane_in = accept ? {1'b1, in_data[i*DATA_W +: DATA_W]} : '0;

    skew_delay_line #(
      .DEPTH (i),
      .WIDTH (LANE_W)
    ) u_skew (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (lane_in),
      .q_o   (lane_out)
    );

    assign row_out[i*DATA_W +: DATA_W] = lane_out[DATA_W-1:0];
    assign row_vld[i]                  = lane_out[DATA_W];
  end

endmodule
